thd_meas_ctrl: RTL
==================

# thd_meas_ctrl

Measurement sequencer for the THD analysis chain. On a start request it waits for the fundamental frequency from the frequency meter and derives a sample-rate divider from it. It then captures a fixed-length record of ADC samples into the sample buffer at that rate, launches the spectrum/THD processor and reports completion or error. It sits between `wave_freq`, the ADC input, the sample RAM and the FFT/THD engine, all on the 50 MHz system clock.

## Interface
Parameters:
- `CLK_KHZ`, 50000: system clock in kHz; dividend for the divider computation (must fit 16 bits).
- `OSR_LOG2`, 4: log2 of samples per fundamental period (fs = freq·2^OSR_LOG2 kHz).
- `NPTS_LOG2`, 10: log2 of record length (1024 samples).
- `TIMEOUT_CYC`, 50_000_000: maximum cycles to wait for `freq_valid`.

Ports:
- `clk_50m`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a measurement.
- `abort`  in  1  cancel current measurement.
- `freq`  in  8  fundamental in kHz from `wave_freq`; valid range 1..100.
- `freq_valid`  in  1  `freq` qualifier (already synchronous to `clk_50m`).
- `ad_data`  in  10  ADC sample.
- `proc_done`  in  1  one-cycle completion pulse from the THD processor.
- `buf_we`  out  1  sample RAM write enable.
- `buf_addr`  out  NPTS_LOG2  sample RAM address.
- `buf_din`  out  10  sample RAM write data.
- `proc_start`  out  1  one-cycle launch pulse to the processor.
- `meas_freq`  out  8  latched fundamental.
- `samp_div`  out  16  computed sample period in clocks.
- `busy`  out  1  high in every state except IDLE/ERR.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  2  0 none, 1 frequency timeout, 2 frequency out of range.

## Operation
- FSM states: IDLE, WAIT_FREQ, CALC_DIV, CAPTURE, WAIT_PROC, ERR.
- **IDLE:** `start` moves to WAIT_FREQ, clears `err` and clears the timeout counter.
- **WAIT_FREQ:** on `freq_valid` the block latches `freq` into `meas_freq`.
  - `freq` of 0 or greater than 100: go to ERR with `err`=2.
  - `freq` in range: go to CALC_DIV.
  - Timeout counter reaches TIMEOUT_CYC−1 without `freq_valid`: go to ERR with `err`=1.
  - `freq_valid` in the same cycle as expiry: `freq_valid` wins.
- **CALC_DIV:** sequential restoring divider, one quotient bit per cycle, 16 cycles.
  - `samp_div` = floor(CLK_KHZ / (meas_freq << OSR_LOG2)).
  - The divisor is formed by shifting, with no multiplier.
  - `samp_div` updates only when the division completes; then go to CAPTURE.
- **CAPTURE:** the strobe counter runs 0..samp_div−1, and the strobe fires on the cycle where count = samp_div−1.
  - Each strobe: `buf_we`=1, `buf_din`=`ad_data` from that cycle, `buf_addr`=sample index.
  - The index starts at 0 and increments after each write.
  - After the write at address 2^NPTS_LOG2−1, go to WAIT_PROC.
- **WAIT_PROC:** `proc_start` is pulsed on the first cycle. Wait for `proc_done`, then pulse `done` and return to IDLE. There is no timeout in this state.
- **ERR:** holds `err`. `start` clears `err` and goes to WAIT_FREQ.
- `start` in any busy state is ignored.
- `abort` in any busy state takes effect on the next edge:
  - the FSM goes to IDLE with `buf_we`=0;
  - no `done` and no `proc_start` are issued;
  - `err` is unchanged.
- `abort` takes priority over every other transition in the same cycle, including `start` arriving from IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `proc_start`=0, `buf_we`=0, `buf_addr`=0, `buf_din`=0, `err`=0, `meas_freq`=0, `samp_div`=0; FSM in IDLE.
- Reset is synchronous and overrides every input, including reset mid-capture.
- `busy` rises the cycle after `start` is accepted.
- WAIT_FREQ to CAPTURE takes exactly 16 cycles in CALC_DIV.
- First `buf_we` occurs samp_div cycles after CAPTURE entry; consecutive writes are exactly samp_div cycles apart.
- `proc_start` is asserted the cycle after the last write.
- `done` is asserted the cycle after `proc_done`, with `busy` falling together with `done`.
- All outputs are registered.

## Test plan
- `freq`=10 with `freq_valid` → `samp_div`=312; 1024 writes at 312-cycle spacing; addresses 0..1023; `buf_din` matches a ramp on `ad_data`; `proc_start` 1 cycle after the last write; `proc_done` → `done` 1 cycle later.
- `freq`=100 → `samp_div`=31. `freq`=1 → `samp_div`=3125. In each case, `samp_div` updates 16 cycles after `freq_valid`.
- `freq`=0, then `freq`=150 → `err`=2 and `busy`=0 each time, with no writes. A following `start` with `freq`=20 completes and clears `err` to 0.
- TIMEOUT_CYC=1000 and no `freq_valid` → `err`=2'd1 at cycle 1000 after WAIT_FREQ entry. `freq_valid` exactly at expiry → measurement proceeds.
- `abort` when `buf_addr`=500 → `buf_we` low the next cycle, `busy`=0, no `proc_start`/`done`. A new `start` restarts capture at address 0.
- `start` pulses during CAPTURE → ignored (sequence unchanged). `rst` mid-capture → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/thd_meas_ctrl.sv
// THD measurement sequencer: waits for the fundamental, derives the sample-rate divider,
// captures a fixed-length ADC record into the sample RAM and launches the THD processor.
module thd_meas_ctrl #(
  parameter int CLK_KHZ     = 50000,
  parameter int OSR_LOG2    = 4,
  parameter int NPTS_LOG2   = 10,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           freq,
  input  logic                 freq_valid,
  input  logic [9:0]           ad_data,
  input  logic                 proc_done,
  output logic                 buf_we,
  output logic [NPTS_LOG2-1:0] buf_addr,
  output logic [9:0]           buf_din,
  output logic                 proc_start,
  output logic [7:0]           meas_freq,
  output logic [15:0]          samp_div,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err
);

  localparam int DVS_W = 8 + OSR_LOG2;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]          DIVIDEND  = 16'(CLK_KHZ);
  localparam logic [NPTS_LOG2-1:0] LAST_IDX  = '1;
  localparam logic [1:0]           ERR_NONE  = 2'd0;
  localparam logic [1:0]           ERR_TMO   = 2'd1;
  localparam logic [1:0]           ERR_RANGE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FREQ,
    S_CALC_DIV,
    S_CAPTURE,
    S_WAIT_PROC,
    S_ERR
  } state_t;

  // One restoring-division step: returns {quotient bit, new partial remainder}.
  function automatic logic [DVS_W:0] div_step(input logic [DVS_W-1:0] rem,
                                              input logic             nxt_bit,
                                              input logic [DVS_W-1:0] dvs);
    logic [DVS_W:0] trial;
    trial = {rem, nxt_bit};
    if (trial >= {1'b0, dvs})
      return {1'b1, DVS_W'(trial - {1'b0, dvs})};
    else
      return {1'b0, trial[DVS_W-1:0]};
  endfunction

  function automatic logic freq_in_range(input logic [7:0] f);
    return (f != 8'd0) && (f <= 8'd100);
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [TMO_W-1:0]       r_tmo, w_tmo_nxt;
  logic [3:0]             r_bit, w_bit_nxt;
  logic [15:0]            r_scnt, w_scnt_nxt;
  logic [NPTS_LOG2-1:0]   r_idx, w_idx_nxt;
  logic [DVS_W-1:0]       r_dvs, w_dvs_nxt;
  logic [DVS_W-1:0]       r_rem, w_rem_nxt;
  logic [15:0]            r_quo, w_quo_nxt;
  logic [DVS_W:0]         w_step;

  logic                   r_buf_we, w_buf_we_nxt;
  logic [NPTS_LOG2-1:0]   r_buf_addr, w_buf_addr_nxt;
  logic [9:0]             r_buf_din, w_buf_din_nxt;
  logic                   r_proc_start, w_proc_start_nxt;
  logic [7:0]             r_meas_freq, w_meas_freq_nxt;
  logic [15:0]            r_samp_div, w_samp_div_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic [1:0]             r_err, w_err_nxt;

  // r_quo starts as the dividend and shifts its bits out MSB-first while quotient bits shift in.
  assign w_step = div_step(r_rem, r_quo[15], r_dvs);

  always_comb begin
    w_state_nxt      = r_state;
    w_tmo_nxt        = r_tmo;
    w_bit_nxt        = r_bit;
    w_scnt_nxt       = r_scnt;
    w_idx_nxt        = r_idx;
    w_dvs_nxt        = r_dvs;
    w_rem_nxt        = r_rem;
    w_quo_nxt        = r_quo;
    w_buf_we_nxt     = 1'b0;
    w_buf_addr_nxt   = r_buf_addr;
    w_buf_din_nxt    = r_buf_din;
    w_proc_start_nxt = 1'b0;
    w_meas_freq_nxt  = r_meas_freq;
    w_samp_div_nxt   = r_samp_div;
    w_done_nxt       = 1'b0;
    w_err_nxt        = r_err;
    w_busy_nxt       = 1'b0;

    case (r_state)
      S_IDLE, S_ERR: begin
        if (start) begin
          w_state_nxt = S_WAIT_FREQ;
          w_err_nxt   = ERR_NONE;
          w_tmo_nxt   = '0;
        end
      end

      S_WAIT_FREQ: begin
        w_tmo_nxt = r_tmo + TMO_W'(1);
        if (freq_valid) begin
          w_meas_freq_nxt = freq;
          if (freq_in_range(freq)) begin
            w_state_nxt = S_CALC_DIV;
            w_dvs_nxt   = DVS_W'(freq) << OSR_LOG2;
            w_rem_nxt   = '0;
            w_quo_nxt   = DIVIDEND;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = S_ERR;
            w_err_nxt   = ERR_RANGE;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = ERR_TMO;
        end
      end

      S_CALC_DIV: begin
        w_rem_nxt = w_step[DVS_W-1:0];
        w_quo_nxt = {r_quo[14:0], w_step[DVS_W]};
        w_bit_nxt = r_bit + 4'd1;
        if (r_bit == 4'd15) begin
          w_samp_div_nxt = {r_quo[14:0], w_step[DVS_W]};
          w_state_nxt    = S_CAPTURE;
          w_scnt_nxt     = '0;
          w_idx_nxt      = '0;
        end
      end

      S_CAPTURE: begin
        if (r_scnt == r_samp_div - 16'd1) begin
          w_scnt_nxt     = '0;
          w_buf_we_nxt   = 1'b1;
          w_buf_addr_nxt = r_idx;
          w_buf_din_nxt  = ad_data;
          w_idx_nxt      = r_idx + NPTS_LOG2'(1);
          if (r_idx == LAST_IDX)
            w_state_nxt = S_WAIT_PROC;
        end else begin
          w_scnt_nxt = r_scnt + 16'd1;
        end
      end

      S_WAIT_PROC: begin
        // The first WAIT_PROC cycle is exactly the cycle that shows the final write.
        w_proc_start_nxt = r_buf_we;
        if (proc_done) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    if (abort) begin
      w_state_nxt      = (r_state == S_ERR) ? S_ERR : S_IDLE;
      w_err_nxt        = r_err;
      w_buf_we_nxt     = 1'b0;
      w_buf_addr_nxt   = r_buf_addr;
      w_buf_din_nxt    = r_buf_din;
      w_proc_start_nxt = 1'b0;
      w_done_nxt       = 1'b0;
      w_meas_freq_nxt  = r_meas_freq;
      w_samp_div_nxt   = r_samp_div;
    end

    w_busy_nxt = !(w_state_nxt inside {S_IDLE, S_ERR});
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tmo        <= '0;
      r_bit        <= '0;
      r_scnt       <= '0;
      r_idx        <= '0;
      r_buf_we     <= 1'b0;
      r_buf_addr   <= '0;
      r_buf_din    <= '0;
      r_proc_start <= 1'b0;
      r_meas_freq  <= '0;
      r_samp_div   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= ERR_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_tmo        <= w_tmo_nxt;
      r_bit        <= w_bit_nxt;
      r_scnt       <= w_scnt_nxt;
      r_idx        <= w_idx_nxt;
      r_buf_we     <= w_buf_we_nxt;
      r_buf_addr   <= w_buf_addr_nxt;
      r_buf_din    <= w_buf_din_nxt;
      r_proc_start <= w_proc_start_nxt;
      r_meas_freq  <= w_meas_freq_nxt;
      r_samp_div   <= w_samp_div_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_ff @(posedge clk_50m) begin
    r_dvs <= w_dvs_nxt;
    r_rem <= w_rem_nxt;
    r_quo <= w_quo_nxt;
  end

  assign buf_we     = r_buf_we;
  assign buf_addr   = r_buf_addr;
  assign buf_din    = r_buf_din;
  assign proc_start = r_proc_start;
  assign meas_freq  = r_meas_freq;
  assign samp_div   = r_samp_div;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
